booth_radix4_multiplier: RTL and testbench

//  Sequential radix-4 Booth multiplier; next generation of the radix-2 Multiplier block.

---
 rtl/booth_pkg.sv | 27 ++
 rtl/booth_radix4_multiplier_if.sv | 22 ++
 rtl/booth_r4_recoder.sv | 21 ++
 rtl/booth_radix4_multiplier.sv | 172 +++++++++++++++++
 tb/tb_booth_radix4_multiplier.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Configuration macro: BOOTH_ZERO_BYPASS_EN (see booth_radix4_multiplier.sv).
package booth_pkg;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Recoded radix-4 Booth digit.
    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Iterations needed: operands are widened by two bits (sign/zero room
    // plus evenness), and each iteration retires two multiplier bits.
    function automatic int iter_count(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_radix4_multiplier_if.sv
// Begin/Busy/Done handshake and operand/result bus of the Booth multiplier.
interface booth_radix4_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                 Begin;
    logic [WIDTH-1:0]     Multiplicand;
    logic [WIDTH-1:0]     Multiplier;
    logic                 Signed;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   Product;

    modport master (
        output Begin, Multiplicand, Multiplier, Signed,
        input  Busy, Done, Product
    );

    modport slave (
        input  Begin, Multiplicand, Multiplier, Signed,
        output Busy, Done, Product
    );
endinterface

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: {Q[1], Q[0], q_m1} window to a signed digit.
import booth_pkg::*;

module booth_r4_recoder (
    input  logic [2:0] window,
    output digit_t     digit
);

    // Standard Booth table; 000 and 111 both mean "no add".
    always_comb begin
        digit = ZERO;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// Operands are extended to WIDTH+2 bits so both modes run the same
// N = WIDTH/2+1 iterations; the low 2*WIDTH bits of {A,Q} are the product.
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips RUN entirely.
import booth_pkg::*;

module booth_radix4_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    booth_radix4_multiplier_if.slave      bus
);

    localparam int W2 = WIDTH + 2;
    localparam int N  = iter_count(WIDTH);
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t            state, state_n;
    logic [W2:0]       acc;          // A, one guard bit above W2 for 2M
    logic [W2-1:0]     q;
    logic              q_m1;
    logic [W2-1:0]     m;
    logic [CW-1:0]     cnt;
    logic [2*WIDTH-1:0] product;
    logic              done_r;
`ifdef BOOTH_ZERO_BYPASS_EN
    logic              zbyp;         // extra DONE dwell for bypassed ops
    logic              zero_op;
`endif

    logic [W2-1:0]     m_ext, q_ext;
    logic              accept;
    digit_t            digit;
    logic [W2:0]       m_a, addend, sum;
    logic [W2:0]       acc_sh;
    logic [W2-1:0]     q_sh;

    assign accept = (state == IDLE) && bus.Begin;

    // Widen operands: sign-extend in signed mode, zero-extend otherwise.
    assign m_ext = bus.Signed ? {{2{bus.Multiplicand[WIDTH-1]}}, bus.Multiplicand}
                              : {2'b00, bus.Multiplicand};
    assign q_ext = bus.Signed ? {{2{bus.Multiplier[WIDTH-1]}}, bus.Multiplier}
                              : {2'b00, bus.Multiplier};

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zero_op = (bus.Multiplicand == '0) || (bus.Multiplier == '0);
`endif

    booth_r4_recoder u_recoder (
        .window ({q[1], q[0], q_m1}),
        .digit  (digit)
    );

    // Select the partial product for this iteration and accumulate.
    assign m_a = {m[W2-1], m};
    always_comb begin
        addend = '0;
        case (digit)
            POS1:    addend = m_a;
            POS2:    addend = {m, 1'b0};
            NEG1:    addend = -m_a;
            NEG2:    addend = -{m, 1'b0};
            default: addend = '0;
        endcase
    end
    assign sum = acc + addend;

    // Arithmetic shift of {sum, Q, q_m1} right by two.
    assign acc_sh = {{2{sum[W2]}}, sum[W2:2]};
    assign q_sh   = {sum[1:0], q[W2-1:2]};

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.Begin) begin
`ifdef BOOTH_ZERO_BYPASS_EN
                    state_n = zero_op ? DONE : RUN;
`else
                    state_n = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) state_n = DONE;
            end
            DONE: begin
`ifdef BOOTH_ZERO_BYPASS_EN
                state_n = zbyp ? DONE : IDLE;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, iterations, and result register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
            done_r  <= 1'b0;
`ifdef BOOTH_ZERO_BYPASS_EN
            zbyp    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc  <= '0;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
`ifdef BOOTH_ZERO_BYPASS_EN
                        zbyp <= zero_op;
                        m    <= zero_op ? '0 : m_ext;
                        q    <= zero_op ? '0 : q_ext;
`else
                        m    <= m_ext;
                        q    <= q_ext;
`endif
                    end
                end
                RUN: begin
                    acc  <= acc_sh;
                    q    <= q_sh;
                    q_m1 <= q[1];
                    cnt  <= cnt + 1'b1;
                end
                DONE: begin
`ifdef BOOTH_ZERO_BYPASS_EN
                    if (zbyp) begin
                        zbyp <= 1'b0;
                    end else begin
                        product <= {acc[WIDTH-3:0], q};
                        done_r  <= 1'b1;
                    end
`else
                    product <= {acc[WIDTH-3:0], q};
                    done_r  <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy    = (state != IDLE);
    assign bus.Done    = done_r;
    assign bus.Product = product;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench for booth_radix4_multiplier at WIDTH=16.
module tb_booth_radix4_multiplier;

    localparam int WIDTH = 16;
`ifdef BOOTH_ZERO_BYPASS_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 10;
`endif

    typedef struct {
        logic [31:0] prod;
        int          due;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    booth_radix4_multiplier_if #(.WIDTH(WIDTH)) bus ();

    booth_radix4_multiplier #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
        logic signed [31:0] sa, sb2;
        if (s) begin
            sa  = {{16{a[15]}}, a};
            sb2 = {{16{b[15]}}, b};
            return 32'(sa * sb2);
        end
        return {16'b0, a} * {16'b0, b};
    endfunction

    // Compare each Done against the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RST && bus.Done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", bus.Product, e.prod);
                chk("latency", cyc, e.due);
                chk("busy_at_done", bus.Busy, 0);
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40 && bus.Busy; i++) @(negedge CLK);
        chk("idle_wait", bus.Busy, 0);
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic [31:0] exp, input int lat, input bit push);
        exp_t e;
        wait_idle();
        bus.Begin = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier = b;
        bus.Signed = s;
        @(posedge CLK);
        #1;
        e.prod = exp;
        e.due  = cyc + lat;
        if (push) sb.push_back(e);
        @(negedge CLK);
        bus.Begin = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [15:0] a, b;
        logic        s;
        bus.Begin = 1'b0;
        bus.Multiplicand = '0;
        bus.Multiplier = '0;
        bus.Signed = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.Done, 0);
        chk("rst_product", bus.Product, 0);
        RST = 1'b0;
        @(negedge CLK);

        start_op(16'h8000, 16'h0045, 1'b1, 32'hFFDD8000, 10, 1'b1); drain();
        start_op(16'h07FF, 16'h00FF, 1'b1, 32'h0007F701, 10, 1'b1); drain();
        start_op(16'hFFFF, 16'h00FF, 1'b1, 32'hFFFFFF01, 10, 1'b1); drain();
        start_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 10, 1'b1); drain();
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 10, 1'b1); drain();
        start_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, 10, 1'b1); drain();
        start_op(16'h8000, 16'h8000, 1'b0, 32'h40000000, 10, 1'b1); drain();
        start_op(16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 10, 1'b1); drain();

        // Begin re-pulsed while busy with different operands: ignored.
        start_op(16'h1234, 16'h0056, 1'b0, 32'h00061D78, 10, 1'b1);
        repeat (3) @(negedge CLK);
        bus.Begin = 1'b1;
        bus.Multiplicand = 16'hAAAA;
        bus.Multiplier = 16'h5555;
        bus.Signed = 1'b1;
        @(negedge CLK);
        bus.Begin = 1'b0;
        drain();
        repeat (12) @(negedge CLK);

        // Reset four cycles into RUN aborts the operation silently.
        start_op(16'h4321, 16'h1111, 1'b0, 32'h0, 10, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_busy", bus.Busy, 0);
        chk("abort_done", bus.Done, 0);
        chk("abort_product", bus.Product, 0);
        repeat (15) @(negedge CLK);
        chk("abort_product_hold", bus.Product, 0);

        start_op(16'h0003, 16'hFFFD, 1'b1, 32'hFFFFFFF7, 10, 1'b1); drain();

        // Zero operand.
        start_op(16'h0000, 16'h1234, 1'b0, 32'h0, ZLAT, 1'b1); drain();
        start_op(16'h1234, 16'h0000, 1'b1, 32'h0, ZLAT, 1'b1); drain();

        // Randomised, back-to-back.
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            start_op(a, b, s, golden(a, b, s),
                     (a == 0 || b == 0) ? ZLAT : 10, 1'b1);
        end
        drain();
        repeat (4) @(negedge CLK);
        chk("final_idle", bus.Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
